// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner
//   Time-multiplexed scan controller for a 4-digit, common-anode
//   seven-segment display. It drives the 2-bit address of an external
//   2-to-4 anode decoder and the shared active-low cathodes. The display
//   inputs are snapshotted once per frame, on the 3->0 address wrap, so a
//   frame never mixes old and new values.
//
//   Optional feature: define SSEG_GHOST_BLANK_EN to blank the cathodes for
//   the first BLANK_CYCLES cycles of every digit slot (anti-ghosting).
//
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   data       in   [15:0] four hex nibbles, digit 0 = data[3:0]
//   dp         in   [3:0]  per-digit decimal point request, active-high
//   digit_en   in   [3:0]  per-digit enable, active-high
//   addr       out  [1:0]  digit address to the anode decoder
//   seg        out  [6:0]  cathodes {g,f,e,d,c,b,a}, active-low
//   dp_out     out         decimal-point cathode, active-low
//   scan_tick  out         one-cycle pulse in the first cycle of each addr
module seven_seg_scanner #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic [3:0]  digit_en,
  output logic [1:0]  addr,
  output logic [6:0]  seg,
  output logic        dp_out,
  output logic        scan_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
`ifdef SSEG_GHOST_BLANK_EN
  localparam logic [CW-1:0] BLANK_W = CW'(BLANK_CYCLES);
`endif

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    addr_q, addr_d;
  logic [15:0]   snap_data_q, snap_data_d;
  logic [3:0]    snap_dp_q, snap_dp_d;
  logic [3:0]    snap_en_q, snap_en_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_out_q, dp_out_d;
  logic          tick_q, tick_d;
  logic          wrap, load, blank;
  logic [3:0]    nib;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  // The cathode registers are computed from the *next* address and the
  // *next* snapshot, so seg/dp_out always line up with the addr value that
  // lands on the same edge (including the freshly loaded digit 0 on a wrap).
  always_comb begin
    wrap        = (cnt_q == CNT_MAX);
    load        = wrap && (addr_q == 2'd3);
    cnt_d       = wrap ? '0 : cnt_q + CW'(1);
    addr_d      = wrap ? addr_q + 2'd1 : addr_q;
    tick_d      = wrap;
    snap_data_d = load ? data     : snap_data_q;
    snap_dp_d   = load ? dp       : snap_dp_q;
    snap_en_d   = load ? digit_en : snap_en_q;
    nib         = snap_data_d[{addr_d, 2'b00} +: 4];
    blank       = ~snap_en_d[addr_d];
`ifdef SSEG_GHOST_BLANK_EN
    // Matches the registered cnt that will be current alongside seg.
    if (cnt_d < BLANK_W) blank = 1'b1;
`endif
    seg_d       = blank ? 7'h7F : glyph(nib);
    dp_out_d    = blank ? 1'b1  : ~snap_dp_d[addr_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      addr_q      <= 2'd0;
      snap_data_q <= 16'h0000;
      snap_dp_q   <= 4'h0;
      snap_en_q   <= 4'h0;
      seg_q       <= 7'h7F;
      dp_out_q    <= 1'b1;
      tick_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      snap_data_q <= snap_data_d;
      snap_dp_q   <= snap_dp_d;
      snap_en_q   <= snap_en_d;
      seg_q       <= seg_d;
      dp_out_q    <= dp_out_d;
      tick_q      <= tick_d;
    end
  end

  assign addr      = addr_q;
  assign seg       = seg_q;
  assign dp_out    = dp_out_q;
  assign scan_tick = tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
module tb_seven_seg_scanner;
  localparam int R = 4;
  localparam int B = 2;
`ifdef SSEG_GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data = 16'h1234;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic [1:0]  addr;
  logic [6:0]  seg;
  logic        dp_out;
  logic        scan_tick;

  int total = 0;
  int bad   = 0;

  seven_seg_scanner #(.REFRESH_DIV(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .rst(rst), .data(data), .dp(dp), .digit_en(digit_en),
    .addr(addr), .seg(seg), .dp_out(dp_out), .scan_tick(scan_tick)
  );

  always #5 clk = ~clk;

  logic [6:0] GLY [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: e = rising edges since reset release; snapshot reloads every
  // 4*R edges from whatever the inputs hold on that edge.
  int          e = 0;
  logic [3:0]  m_nib [4];
  logic [3:0]  m_dp, m_en;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      e = 0;
      for (int i = 0; i < 4; i++) m_nib[i] = 4'h0;
      m_dp = 4'h0;
      m_en = 4'h0;
    end else begin
      e = e + 1;
      if (e % (4 * R) == 0) begin
        for (int i = 0; i < 4; i++) m_nib[i] = data[i*4 +: 4];
        m_dp = dp;
        m_en = digit_en;
      end
    end
  end

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (edge %0d)", name, got, exp, e);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    int a, c, t;
    logic bl;
    logic [6:0] es;
    logic ed;
    a  = (e / R) % 4;
    c  = e % R;
    t  = (e > 0 && c == 0) ? 1 : 0;
    bl = !m_en[a] || (GHOST && c < B);
    es = bl ? 7'h7F : GLY[m_nib[a]];
    ed = bl ? 1'b1 : ~m_dp[a];
    chk("cyc_addr", addr, a);
    chk("cyc_tick", scan_tick, t);
    chk("cyc_seg", seg, es);
    chk("cyc_dp", dp_out, ed);
  end

  task automatic wait_edge(input int n);
    int g = 0;
    while (e < n && g < 5000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("wait_edge", e, n);
  endtask

  initial begin
    // Reset held.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", addr, 0);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_dp", dp_out, 1);
    chk("rst_tick", scan_tick, 0);
    @(negedge clk);
    rst = 1'b0;

    // First frame blank.
    wait_edge(8);
    chk("f0_blank", seg, 7'h7F);
    wait_edge(16);
    chk("e16_addr", addr, 0);
    chk("e16_tick", scan_tick, 1);
    wait_edge(17);
    chk("e17_tick", scan_tick, 0);
    wait_edge(18);
    chk("e18_seg4", seg, 7'b0011001);
    data = 16'hABCD;               // must not show until edge 32
    wait_edge(20);
    chk("e20_addr", addr, 1);
    wait_edge(22);
    chk("e22_seg3", seg, 7'b0110000);
    wait_edge(30);
    chk("e30_addr", addr, 3);
    chk("e30_seg1", seg, 7'b1111001);
    wait_edge(34);
    chk("e34_segd", seg, 7'b0100001);

    // Enable / decimal point, loaded at edge 48.
    digit_en = 4'b1101;
    dp       = 4'b0001;
    wait_edge(50);
    chk("d0_dp", dp_out, 0);
    wait_edge(54);
    chk("d1_blank", seg, 7'h7F);
    chk("d1_dp", dp_out, 1);
    wait_edge(58);
    chk("d2_segB", seg, 7'b0000011);
    chk("d2_dp", dp_out, 1);

    // Async reset mid-cycle during the addr=2 slot.
    #3;
    rst = 1'b1;
    #1;
    chk("ar_addr", addr, 0);
    chk("ar_seg", seg, 7'h7F);
    chk("ar_dp", dp_out, 1);
    chk("ar_tick", scan_tick, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    data     = 16'h5E0F;
    digit_en = 4'hF;
    dp       = 4'b1010;
    wait_edge(3);
    chk("ar_e3_addr", addr, 0);
    wait_edge(4);
    chk("ar_e4_addr", addr, 1);
    chk("ar_e4_tick", scan_tick, 1);
    wait_edge(18);
    chk("r_segF", seg, 7'b0001110);
    wait_edge(22);
    chk("r_seg0", seg, 7'b1000000);
    chk("r_dp1", dp_out, 0);
    wait_edge(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Time-multiplexed scan controller for the board's 4-digit seven-segment display. It sits directly upstream of the 2-to-4 anode decoder: it generates the 2-bit digit address that drives the decoder's `Addr1`/`Addr0` inputs, and it drives the shared, active-low cathode lines with the hex glyph for the addressed digit. Display data is snapshotted once per frame, so a frame never shows a mix of old and new values.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles each digit is held (1 kHz per digit at 100 MHz). Minimum 2.
- `BLANK_CYCLES`, default 1024: ghost-blank length in cycles. Used only with `SSEG_GHOST_BLANK_EN`; must be less than `REFRESH_DIV`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `data`  in  16  four hex nibbles; digit 0 = `data[3:0]`, digit 3 = `data[15:12]`.
- `dp`  in  4  per-digit decimal-point request, active-high; bit i belongs to digit i.
- `digit_en`  in  4  per-digit enable, active-high. A 0 blanks that digit.
- `addr`  out  2  digit address to the decoder; `addr[0]` goes to `Addr0`, `addr[1]` goes to `Addr1`.
- `seg`  out  7  cathodes `{g,f,e,d,c,b,a}`, active-low.
- `dp_out`  out  1  decimal-point cathode, active-low.
- `scan_tick`  out  1  one-cycle pulse, high in the first cycle of each new `addr` value.

## Operation
- Prescaler `cnt` counts 0..`REFRESH_DIV`-1.
- On the edge where `cnt == REFRESH_DIV-1`:
  - `cnt` returns to 0.
  - `addr` increments, wrapping 3→0.
  - `scan_tick` is registered high for one cycle.
- Frame length: 4·`REFRESH_DIV` cycles.
- Snapshot registers `snap_data` (16), `snap_dp` (4) and `snap_en` (4) load from `data`, `dp` and `digit_en` only on the edge where `addr` wraps 3→0.
  - Input changes at any other time have no effect until the next wrap.
- `seg`, `dp_out` and `addr` are all registered and update on the same edge. The glyph always matches the address the decoder is enabling.
  - On the wrap edge, the digit-0 glyph is computed from the values being loaded that edge.
- Glyph, selected by nibble n = `snap_data[4·addr +: 4]`, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- If `snap_en[addr] == 0`: `seg = 7'h7F` and `dp_out = 1`.
- Otherwise: `dp_out = ~snap_dp[addr]`.
- Reset values:
  - `cnt = 0`, `addr = 0`, `seg = 7'h7F`, `dp_out = 1`, `scan_tick = 0`.
  - All snapshot registers are 0, so the first frame after reset is fully blank.
- Reset asserted mid-frame clears everything immediately, with no clock needed. Scanning restarts from digit 0 with `cnt = 0` on the first edge after `rst` falls.

## Timing
- After reset release, `addr` changes on edges k·`REFRESH_DIV` (counting edges from release as 1, 2, …). The first 3→0 wrap, and so the first data load, is at edge 4·`REFRESH_DIV`.
- Data latency: a `data` change becomes visible 1 to 4·`REFRESH_DIV` cycles later, on the next wrap.
- `scan_tick` goes high in the same cycle `addr` takes its new value. It is never high two cycles in a row, except when `REFRESH_DIV = 1`, which is disallowed.

## Configuration
- Macro: `SSEG_GHOST_BLANK_EN`.
- Defined: while `cnt < BLANK_CYCLES`, i.e. for the first `BLANK_CYCLES` cycles of every digit slot:
  - `seg = 7'h7F` and `dp_out = 1`, regardless of `snap_en`.
  - The glyph is driven for the remainder of the slot.
  - This suppresses ghosting while the anodes switch.
- Undefined: there is no blanking interval, glyphs are driven for the full slot, and `BLANK_CYCLES` is ignored.

## Test plan
All scenarios use `REFRESH_DIV = 4`.
- Reset: hold `rst` high, toggle `clk` → `addr = 0`, `seg = 7F`, `dp_out = 1`, `scan_tick = 0` throughout.
- First frame: release reset with `data = 16'h1234`, `digit_en = F` → `seg = 7F` for edges 1–15.
  - Edge 16: `addr = 0`, `seg = 0011001` ('4'), `scan_tick = 1`.
  - Edge 20: `addr = 1`, `seg = 0110000` ('3').
  - Edge 28: `addr = 3`, `seg = 1111001` ('1').
- Snapshot hold: change `data` to `16'hABCD` at edge 18 → digits still show 4/3/2/1 until edge 32.
  - Edge 32: `seg = 0100001` ('d').
- Enable and decimal point: `digit_en = 4'b1101`, `dp = 4'b0001` → digit 1 slot shows `seg = 7F`; digit 0 slot shows `dp_out = 0`; other slots show `dp_out = 1`.
- Async reset: assert `rst` mid-cycle during the `addr = 2` slot → outputs take their reset values before the next edge; after release, `addr` reaches 1 at edge 4.
- Macro defined, `BLANK_CYCLES = 2`: in every slot, `seg = 7F` in the slot's first two cycles and shows the glyph in the last two.
